// File: rtl/uart_tx_prescaled.sv
// UART transmitter sharing the receiver's oversampled clock and PRESCALE setting.
// Sends one latched word per DATA_VALID handshake: start, data LSB first, optional parity, stop.
//
// state    | meaning
// S_IDLE   | line high, waiting for DATA_VALID
// S_START  | start bit (low) for P cycles
// S_DATA   | data bit bit_cnt for P cycles, LSB first
// S_PARITY | parity bit for P cycles (only when parity enabled)
// S_STOP   | stop bit (high) for P cycles, FRAME_DONE on its last cycle
module uart_tx_prescaled #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic [5:0]             period_q;
    logic [5:0]             presc_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    logic                   bit_end;
    logic                   stop_penult;
    logic                   parity_bit;
    logic [BIT_CNT_W-1:0]   bit_nxt;

    assign bit_end     = (presc_cnt == (period_q - 6'd1));
    assign stop_penult = (presc_cnt == (period_q - 6'd2));
    assign parity_bit  = par_typ_q ? ~(^data_q) : (^data_q);
    assign bit_nxt     = bit_cnt + BIT_CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            TX_OUT     <= 1'b1;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            period_q   <= 6'd4;
            presc_cnt  <= '0;
            bit_cnt    <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    TX_OUT <= 1'b1;
                    BUSY   <= 1'b0;
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        // Periods below 4 are clamped so the STOP-bit pulse timing stays valid.
                        period_q  <= (PRESCALE < 6'd4) ? 6'd4 : PRESCALE;
                        presc_cnt <= '0;
                        bit_cnt   <= '0;
                        TX_OUT    <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        presc_cnt <= '0;
                        TX_OUT    <= data_q[0];
                        state     <= S_DATA;
                    end else begin
                        presc_cnt <= presc_cnt + 6'd1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        presc_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en_q) begin
                                TX_OUT <= parity_bit;
                                state  <= S_PARITY;
                            end else begin
                                TX_OUT <= 1'b1;
                                state  <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_nxt;
                            TX_OUT  <= data_q[bit_nxt];
                        end
                    end else begin
                        presc_cnt <= presc_cnt + 6'd1;
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        presc_cnt <= '0;
                        TX_OUT    <= 1'b1;
                        state     <= S_STOP;
                    end else begin
                        presc_cnt <= presc_cnt + 6'd1;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        presc_cnt <= '0;
                        TX_OUT    <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        presc_cnt <= presc_cnt + 6'd1;
                        // Registered one cycle early so the pulse lands on the final stop cycle.
                        if (stop_penult) begin
                            FRAME_DONE <= 1'b1;
                        end
                    end
                end

                default: begin
                    TX_OUT    <= 1'b1;
                    BUSY      <= 1'b0;
                    presc_cnt <= '0;
                    bit_cnt   <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Bench for uart_tx_prescaled: directed stimulus, expected frames queued and checked
// cycle by cycle against the serial line by a monitor.
module tb_uart_tx_prescaled;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    uart_tx_prescaled #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .PRESCALE   (prescale),
        .TX_OUT     (tx_out),
        .BUSY       (busy),
        .FRAME_DONE (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        int         presc;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_pushed = 0;
    int   frames_seen = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int eff_p(input int presc);
        return (presc < 4) ? 4 : presc;
    endfunction

    function automatic logic frame_bit(input exp_t e, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return e.data[slot-1];
        if (e.par_en && slot == 9) return e.par_typ ? ~(^e.data) : (^e.data);
        return 1'b1;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic pt,
                            input int presc, input bit b2b);
        exp_t e;
        e.data = d; e.par_en = pe; e.par_typ = pt; e.presc = presc; e.b2b = b2b;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: pops one expected frame per BUSY rise and checks every line cycle.
    exp_t cur;
    bit   in_frame = 1'b0;
    int   cyc, flen, idle_cnt, tx_err, busy_err, fd_err;
    int   idle_err = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
            idle_cnt = 0;
        end else begin
            if (!in_frame && busy === 1'b1) begin
                chk("frame_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    cyc = 0;
                    tx_err = 0; busy_err = 0; fd_err = 0;
                    flen = eff_p(cur.presc) * (10 + int'(cur.par_en));
                    if (cur.b2b) chk($sformatf("gap_before_%0h", cur.data), idle_cnt, 1);
                end
            end
            if (in_frame) begin
                if (tx_out !== frame_bit(cur, cyc / eff_p(cur.presc))) tx_err++;
                if (busy !== 1'b1) busy_err++;
                if (frame_done !== logic'(cyc == flen - 1)) fd_err++;
                cyc++;
                if (cyc == flen) begin
                    chk($sformatf("line_%0h_pe%0d_pt%0d", cur.data, cur.par_en, cur.par_typ), tx_err, 0);
                    chk($sformatf("busy_%0h", cur.data), busy_err, 0);
                    chk($sformatf("frame_done_%0h", cur.data), fd_err, 0);
                    frames_seen++;
                    in_frame = 1'b0;
                    idle_cnt = 0;
                end
            end else begin
                if (tx_out !== 1'b1 || frame_done !== 1'b0) idle_err++;
                idle_cnt++;
            end
        end
    end

    task automatic wait_busy(input logic val, input string tag);
        int n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (busy === val) break;
            n++;
        end
        chk(tag, 32'(busy), 32'(val));
    endtask

    // Single-pulse frame: checks latency, BUSY length and FRAME_DONE position.
    task automatic send_pulse(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] presc, input int exp_len, input string tag);
        int cnt;
        int fd_at;
        p_data = d; par_en = pe; par_typ = pt; prescale = presc;
        data_valid = 1'b1;
        push_exp(d, pe, pt, int'(presc), 1'b0);
        @(negedge clk);
        data_valid = 1'b0;
        chk({tag, "_lat_tx"}, 32'(tx_out), 0);
        chk({tag, "_lat_busy"}, 32'(busy), 1);
        cnt = 1;
        fd_at = (frame_done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
            if (frame_done === 1'b1) fd_at = cnt;
        end
        chk({tag, "_busy_len"}, cnt, exp_len);
        chk({tag, "_fd_at"}, fd_at, exp_len);
    endtask

    initial begin
        int ierr;
        rst = 1'b0; data_valid = 1'b0; p_data = '0;
        par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fd", 32'(frame_done), 0);
        rst = 1'b1;
        mon_en = 1'b1;

        ierr = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) ierr++;
        end
        chk("idle20", ierr, 0);

        send_pulse(8'hA5, 1'b0, 1'b0, 6'd8, 80, "a5_nopar");
        send_pulse(8'hA5, 1'b1, 1'b0, 6'd8, 88, "a5_even");
        send_pulse(8'hA5, 1'b1, 1'b1, 6'd8, 88, "a5_odd");
        send_pulse(8'h96, 1'b0, 1'b0, 6'd2, 40, "clamp2");
        send_pulse(8'h0F, 1'b0, 1'b0, 6'd0, 40, "clamp0");
        send_pulse(8'h5A, 1'b1, 1'b1, 6'd63, 693, "p63");

        // Back-to-back with inputs changed while frames are in flight.
        p_data = 8'h3C; prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        data_valid = 1'b1;
        push_exp(8'h3C, 1'b1, 1'b0, 16, 1'b0);
        wait_busy(1'b1, "b2b_acc1");
        p_data = 8'hC3; par_typ = 1'b1;
        push_exp(8'hC3, 1'b1, 1'b1, 16, 1'b1);
        wait_busy(1'b0, "b2b_gap");
        wait_busy(1'b1, "b2b_acc2");
        data_valid = 1'b0;
        p_data = 8'hFF; prescale = 6'd5; par_typ = 1'b0; par_en = 1'b0;
        wait_busy(1'b0, "b2b_end");

        // Every byte value, parity off then on, DATA_VALID held high throughout.
        for (int pe = 0; pe < 2; pe++) begin
            prescale = 6'd8;
            par_en = logic'(pe);
            data_valid = 1'b1;
            for (int v = 0; v < 256; v++) begin
                p_data = 8'(v);
                par_typ = (pe == 1) ? logic'(v % 2) : 1'b0;
                push_exp(8'(v), logic'(pe), par_typ, 8, v != 0);
                wait_busy(1'b1, "lb_acc");
                if (v == 255) data_valid = 1'b0;
                wait_busy(1'b0, "lb_done");
            end
        end

        // Abort during data bit 3 (low for 0xA5); frame is not scoreboarded.
        mon_en = 1'b0;
        p_data = 8'hA5; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (34) @(negedge clk);
        chk("abort_pre_tx", 32'(tx_out), 0);
        chk("abort_pre_busy", 32'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(tx_out), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fd", 32'(frame_done), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_tx", 32'(tx_out), 1);
        chk("post_abort_fd", 32'(frame_done), 0);
        mon_en = 1'b1;
        @(negedge clk);
        send_pulse(8'h69, 1'b1, 1'b0, 6'd8, 88, "after_rst");
        repeat (3) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        chk("frames_seen", frames_seen, n_pushed);
        chk("idle_line", idle_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_prescaled.md
Name: uart_tx_prescaled

Overview:
- UART transmitter that runs on the same oversampled clock domain as the receiver and uses the same PRESCALE configuration, so one clock and one prescale setting serve both directions.
- Serializes one parallel word per handshake into a frame: start, data LSB first, optional parity, stop.
- Bit timing comes from an internal prescale counter, not a separate baud clock.
- Sits beside the existing receiver under the UART top, driving TX_OUT.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- CLK  input  1  oversampled clock (same clock as receiver)
- RST  input  1  synchronous active-low reset
- P_DATA  input  DATA_WIDTH  parallel word to send
- DATA_VALID  input  1  request to send P_DATA
- PAR_EN  input  1  1 = parity bit inserted
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- PRESCALE  input  6  clock cycles per bit
- TX_OUT  output  1  serial line, idle high
- BUSY  output  1  frame in progress
- FRAME_DONE  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset: RST low at a rising CLK edge forces state IDLE, TX_OUT=1, BUSY=0, FRAME_DONE=0, and clears all counters and latches.
- Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- Reset has priority over every other event.

Accept rule:
- A word is accepted on a rising edge where state is IDLE and DATA_VALID=1.
- On acceptance, P_DATA, PAR_EN, PAR_TYP and PRESCALE are latched. Input changes during a frame have no effect.
- DATA_VALID while BUSY=1 is ignored; there is no queue.

Prescale handling:
- Effective bit period P = latched PRESCALE.
- Values 0..3 are clamped to P=4.

State machine: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
- IDLE: TX_OUT=1, BUSY=0.
- START: TX_OUT=0 for P cycles.
- DATA: bit i driven for P cycles, i = 0..DATA_WIDTH-1, LSB first; a bit counter is used.
- PARITY: drives ^data when PAR_TYP=0, ~^data when PAR_TYP=1, for P cycles.
- STOP: TX_OUT=1 for P cycles.

Timing:
- The cycle after acceptance, TX_OUT=0 and BUSY=1 (latency 1).
- BUSY stays high through the last STOP cycle.
- FRAME_DONE=1 coincides with the last STOP cycle.
- The next cycle is IDLE with BUSY=0.
- Frame length = P*(DATA_WIDTH+2+PAR_EN) cycles.

Back-to-back frames:
- DATA_VALID held high is accepted in the first IDLE cycle, so frames are separated by exactly 1 idle-high cycle.

Counters:
- The prescale counter counts 0..P-1 and wraps to 0 on each bit boundary.
- The bit counter is ceil(log2(DATA_WIDTH)) bits and does not wrap within DATA.

Outputs:
- All outputs are registered; no combinational path from inputs to TX_OUT.

Test Plan:
- Reset, then idle 20 cycles -> TX_OUT=1, BUSY=0, FRAME_DONE=0 throughout.
- PRESCALE=8, PAR_EN=0, P_DATA=0xA5, one-cycle DATA_VALID -> line pattern per 8-cycle slot is 0,1,0,1,0,0,1,0,1,1. BUSY is high for exactly 80 cycles, with FRAME_DONE on cycle 80.
- PRESCALE=8, PAR_EN=1, P_DATA=0xA5 -> parity slot is 0 with PAR_TYP=0 and 1 with PAR_TYP=1; frame is 88 cycles.
- DATA_VALID held high with 0x3C then 0xC3, PRESCALE=16 -> two correct frames separated by exactly 1 idle-high cycle. Changing P_DATA, PRESCALE or PAR_TYP mid-frame does not alter the frame in flight.
- PRESCALE=2 -> each bit lasts 4 cycles (clamp). PRESCALE=63 -> each bit lasts 63 cycles.
- Assert RST low during data bit 3 of a frame -> next cycle TX_OUT=1, BUSY=0, no FRAME_DONE. A new DATA_VALID after reset release starts a clean frame.
- Loopback TX_OUT into the existing receiver, both on the same clock, with PRESCALE=8 and all 256 byte values, parity on and off -> RX data matches, with no parity or stop errors.
